pipelined_carry_select_adder: RTL and testbench
===============================================

# pipelined_carry_select_adder

Parametrised, pipelined carry-select adder/subtractor. It is the successor to the fixed 20-bit carry-select adder. Operand width, segment width and segments-per-stage are parameters, and it adds a subtract mode and a valid/ready handshake with backpressure. It sits in the datapath wherever a registered wide add/sub is needed and sustains one result per cycle.

## Interface
Parameters:
- WIDTH, 20, operand width in bits (>= 2)
- SEG, 5, carry-select segment width; last segment is WIDTH - SEG*(NSEG-1) bits wide
- SEG_PER_STG, 2, segments resolved per pipeline stage
- Derived, not overridable: NSEG = ceil(WIDTH/SEG); NSTG = ceil(NSEG/SEG_PER_STG) = latency in cycles

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in; ignored when sub=1
- sub  in  1  0: a+b+cin; 1: a-b, computed as a+~b+1
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH+1  result; sum[WIDTH] = carry-out; in sub mode, 1 = no borrow

## Operation
- Datapath is NSTG register stages. Stage k (k = 0..NSTG-1) resolves segments k*SEG_PER_STG through min((k+1)*SEG_PER_STG, NSEG)-1.
- Each segment computes two ripple sums, one with carry-in 0 and one with carry-in 1. The incoming carry selects between them.
- Within a stage, carries chain combinationally through the stage's segments.
- Carry into stage 0 is cin, or 1 when sub=1. Carry into stage k>0 is the carry-out registered by stage k-1.
- B is inverted at entry when sub=1.
- Operand bits not yet resolved travel forward in skew registers. Resolved sum bits are delayed so that all bits of a beat emerge together at stage NSTG-1.
- Each stage holds a valid bit.
- Advance rule: advance = !out_valid | out_ready. All stage registers load only when advance=1; otherwise all hold.
- in_ready = advance. A beat is accepted iff in_valid & in_ready.
- A stage's valid bit loads from the previous stage's valid bit, or from in_valid & in_ready for stage 0. Bubbles therefore propagate as invalid entries.
- out_valid and sum are driven directly from stage NSTG-1 registers, with no combinational path from a/b to sum.
- Results emerge in acceptance order. None are dropped or duplicated.
- Arithmetic is modulo 2^(WIDTH+1) with the carry as bit WIDTH: sum = {carry, (a + (sub ? ~b : b) + (sub ? 1 : cin)) mod 2^WIDTH}.

## Timing
- Reset (rst=1 at a clk edge): all stage valid bits, all data/carry registers and sum are cleared to 0.
  - out_valid = 0 from the cycle after that edge.
  - in_ready = 1 from the cycle after that edge, since out_valid = 0.
- Reset mid-operation discards all in-flight beats, with no partial output. A beat offered during a reset cycle is not accepted.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NSTG-1, provided no stall occurs. NSTG=1 gives one-cycle registered latency; defaults give 2.
- Throughput: 1 beat per cycle when out_ready is held high.
- Stall: out_valid & !out_ready freezes every stage and holds sum/out_valid stable. in_ready drops in the same cycle, combinationally.
- Capacity is NSTG beats, one per stage.
- Simultaneous accept and output: if out_valid & out_ready & in_valid, one result leaves and one beat enters on the same edge.
- in_ready does not depend on in_valid.
- No other combinational input-to-output paths exist besides out_ready -> in_ready.

## Test plan
- Carry ripple, defaults: a=20'hFFFFF, b=20'h00001, cin=0, sub=0, out_ready=1.
  - Expect out_valid two cycles after accept with sum=21'h100000.
  - With a=20'h0, b=20'h0, cin=1, expect sum=21'h000001.
- Subtract: a=20'h00005, b=20'h00007, sub=1 -> sum=21'h0FFFFE (borrow, bit20=0). a=20'h00007, b=20'h00005, sub=1 -> sum=21'h100002.
- Streaming: 100 random back-to-back beats with mixed sub/cin and out_ready=1.
  - Expect one result per cycle, in order, each equal to a golden a+b+cin (or a-b).
  - Error count 0.
- Backpressure: feed 6 beats continuously while out_ready=0 for 3 cycles after the first result.
  - sum must stay stable during the stall.
  - in_ready=0 while stalled.
  - All 6 results must appear in order, none lost.
- Reset mid-stream: assert rst for one cycle while 2 beats are in flight.
  - Next cycle: out_valid=0, sum=0, in_ready=1.
  - No stale results afterwards.
  - A beat accepted after reset returns correctly with latency 2.
- Parameter sweep: WIDTH=32, SEG=4, SEG_PER_STG=3 (NSTG=3).
  - a=32'hFFFFFFFF, b=32'h1 -> sum=33'h100000000 after 3 cycles.
  - Repeat random streaming.
  - Also WIDTH=20, SEG=5, SEG_PER_STG=4 (NSTG=1, latency 1).

Source files
------------

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor: each stage resolves SEG_PER_STG
// segments; unresolved operand bits ride forward in skew registers.
module pipelined_carry_select_adder #(
  parameter int WIDTH       = 20,
  parameter int SEG         = 5,
  parameter int SEG_PER_STG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int NSEG = (WIDTH + SEG - 1) / SEG;
  localparam int NSTG = (NSEG + SEG_PER_STG - 1) / SEG_PER_STG;

  // Handshake: a beat transfers on any edge where valid & ready are both high.
  // The whole pipe advances together unless the output is held (out_valid & !out_ready),
  // so in_ready is the only signal combinationally dependent on an input (out_ready).
  logic advance;
  logic accept;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  for (genvar k = 0; k < NSTG; k++) begin : stg
    localparam int FIRST = k * SEG_PER_STG;
    localparam int NS    = (NSEG - FIRST < SEG_PER_STG) ? (NSEG - FIRST) : SEG_PER_STG;
    localparam int LO    = FIRST * SEG;
    localparam int HI    = ((FIRST + NS) * SEG > WIDTH) ? WIDTH : (FIRST + NS) * SEG;

    logic [WIDTH-1:LO] a_in;
    logic [WIDTH-1:LO] b_in;
    logic              c_in;
    logic              v_in;
    logic [HI-1:LO]    seg_s;
    logic [NS:0]       cc;
    logic [HI-1:0]     s_d;
    logic              c_d;
    logic [HI-1:0]     s_q;
    logic              c_q;
    logic              valid_q;

    if (k == 0) begin : g_entry
      // Subtraction is a + ~b + 1, so cin is overridden by the forced carry.
      assign a_in = a;
      assign b_in = sub ? ~b : b;
      assign c_in = sub | cin;
      assign v_in = accept;
      assign s_d  = seg_s;
    end else begin : g_link
      assign a_in = stg[k-1].g_skew.a_q;
      assign b_in = stg[k-1].g_skew.b_q;
      assign c_in = stg[k-1].c_q;
      assign v_in = stg[k-1].valid_q;
      assign s_d  = {seg_s, stg[k-1].s_q};
    end

    assign cc[0] = c_in;
    assign c_d   = cc[NS];

    for (genvar j = 0; j < NS; j++) begin : seg
      localparam int SLO = (FIRST + j) * SEG;
      localparam int SHI = (SLO + SEG > WIDTH) ? WIDTH : SLO + SEG;
      localparam int SW  = SHI - SLO;

      logic [SW:0] r0;
      logic [SW:0] r1;

      assign r0 = {1'b0, a_in[SHI-1:SLO]} + {1'b0, b_in[SHI-1:SLO]};
      assign r1 = {1'b0, a_in[SHI-1:SLO]} + {1'b0, b_in[SHI-1:SLO]} + {{SW{1'b0}}, 1'b1};
      assign {cc[j+1], seg_s[SHI-1:SLO]} = cc[j] ? r1 : r0;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        c_q     <= 1'b0;
        s_q     <= '0;
      end else if (advance) begin
        valid_q <= v_in;
        c_q     <= c_d;
        s_q     <= s_d;
      end
    end

    if (k < NSTG - 1) begin : g_skew
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[WIDTH-1:HI];
          b_q <= b_in[WIDTH-1:HI];
        end
      end
    end
  end

  assign out_valid = stg[NSTG-1].valid_q;
  assign sum       = {stg[NSTG-1].c_q, stg[NSTG-1].s_q};

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Bench for pipelined_carry_select_adder: three parameter sets, one active at a time,
// checked against a plain-arithmetic model of a +/- b with carry-out.
module tb_pipelined_carry_select_adder;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic        cin       = 1'b0;
  logic        sub       = 1'b0;
  logic [31:0] a         = '0;
  logic [31:0] b         = '0;
  int          cfg       = 0;

  int          checks    = 0;
  int          errors    = 0;
  logic [32:0] exp_q[$];
  int          acc_q[$];
  int          cyc       = 0;
  int          popped    = 0;
  int          stall_cnt = 0;
  bit          lat_chk   = 1'b0;
  bit          rnd_rdy   = 1'b0;
  bit          prev_stall = 1'b0;
  logic [32:0] prev_sum  = '0;

  logic        iv0, iv1, iv2;
  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic [20:0] s0, s2;
  logic [32:0] s1;
  logic        act_in_ready;
  logic        act_out_valid;
  logic [32:0] act_sum;

  always #5 clk = ~clk;

  assign iv0 = in_valid && (cfg == 0);
  assign iv1 = in_valid && (cfg == 1);
  assign iv2 = in_valid && (cfg == 2);

  pipelined_carry_select_adder #(.WIDTH(20), .SEG(5), .SEG_PER_STG(2)) d0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a[19:0]), .b(b[19:0]),
    .cin(cin), .sub(sub), .out_valid(ov0), .out_ready(out_ready), .sum(s0));

  pipelined_carry_select_adder #(.WIDTH(32), .SEG(4), .SEG_PER_STG(3)) d1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(out_ready), .sum(s1));

  pipelined_carry_select_adder #(.WIDTH(20), .SEG(5), .SEG_PER_STG(4)) d2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a[19:0]), .b(b[19:0]),
    .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(out_ready), .sum(s2));

  always_comb begin
    act_in_ready  = ir0;
    act_out_valid = ov0;
    act_sum       = {12'd0, s0};
    if (cfg == 1) begin
      act_in_ready  = ir1;
      act_out_valid = ov1;
      act_sum       = s1;
    end else if (cfg == 2) begin
      act_in_ready  = ir2;
      act_out_valid = ov2;
      act_sum       = {12'd0, s2};
    end
  end

  function automatic int cfg_w(int c);
    return (c == 1) ? 32 : 20;
  endfunction

  function automatic int cfg_lat(int c);
    return (c == 0) ? 2 : ((c == 1) ? 3 : 1);
  endfunction

  // Golden result: plain integer add on masked operands, carry lands in bit w.
  function automatic logic [32:0] model(int w, logic [31:0] aa, logic [31:0] bb, logic cc, logic ss);
    logic [63:0] mask;
    logic [63:0] t;
    mask = (64'd1 << w) - 64'd1;
    t = (64'(aa) & mask) + ((ss ? ~64'(bb) : 64'(bb)) & mask) + (ss ? 64'd1 : 64'(cc));
    return t[32:0];
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return 32'd0;
      default: return $urandom();
    endcase
  endfunction

  function automatic void chk(string name, logic [32:0] act, logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 99) < 60);
  endtask

  task automatic monitor();
    logic [32:0] e;
    int          ac;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        acc_q.delete();
        prev_stall = 1'b0;
      end else begin
        chk("in_ready_rule", {32'b0, act_in_ready}, {32'b0, (!act_out_valid || out_ready)});
        if (prev_stall) begin
          chk("stall_valid_hold", {32'b0, act_out_valid}, 33'd1);
          chk("stall_sum_hold", act_sum, prev_sum);
        end
        if (act_out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %h with nothing outstanding (t=%0t)", act_sum, $time);
          end else begin
            e  = exp_q.pop_front();
            ac = acc_q.pop_front();
            popped++;
            chk("result", act_sum, e);
            if (lat_chk) chk("latency", 33'(cyc - ac), 33'(cfg_lat(cfg)));
          end
        end
        if (in_valid && act_in_ready) begin
          exp_q.push_back(model(cfg_w(cfg), a, b, cin, sub));
          acc_q.push_back(cyc);
        end
        if (act_out_valid && !out_ready) stall_cnt++;
        prev_stall = act_out_valid && !out_ready;
        prev_sum   = act_sum;
      end
    end
  endtask

  // Holds the beat on the inputs until the block accepts it.
  task automatic offer(input logic [31:0] aa, input logic [31:0] bb, input logic cc, input logic ss);
    bit ok;
    ok = 1'b0;
    a = aa; b = bb; cin = cc; sub = ss; in_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = act_in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL offer_timeout: in_ready stayed 0 for 64 cycles, needed 1");
    end
  endtask

  task automatic send_expect(string name, logic [31:0] aa, logic [31:0] bb, logic cc, logic ss,
                             logic [32:0] exp);
    int got;
    got = 0;
    offer(aa, bb, cc, ss);
    for (int i = 1; i <= 16 && got == 0; i++) begin
      @(negedge clk);
      if (act_out_valid) got = i;
    end
    if (got == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid never rose, needed after %0d cycles", name, cfg_lat(cfg));
    end else begin
      chk(name, act_sum, exp);
      chk({name, "_latency"}, 33'(got), 33'(cfg_lat(cfg)));
    end
    step();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    rnd_rdy  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    repeat (2) step();
    chk("drain_empty", 33'(exp_q.size()), 33'd0);
  endtask

  task automatic stream(int n, int vpct, bit rr);
    rnd_rdy = rr;
    if (!rr) out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) >= vpct) begin
        in_valid = 1'b0;
        step();
      end
      offer(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
  endtask

  task automatic backpressure();
    int p0;
    int st0;
    p0 = popped;
    st0 = stall_cnt;
    lat_chk = 1'b0;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++)
          offer(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!act_out_valid && n < 20);
        step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 33'(popped - p0), 33'd6);
    chk("bp_stalled", 33'(stall_cnt - st0 >= 3), 33'd1);
  endtask

  task automatic reset_mid();
    int seen;
    lat_chk = 1'b0;
    out_ready = 1'b0;
    offer(rnd_op(), rnd_op(), 1'b0, 1'b0);
    offer(rnd_op(), rnd_op(), 1'b1, 1'b1);
    a = $urandom(); b = $urandom(); in_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", {32'b0, act_out_valid}, 33'd0);
    chk("rst_mid_sum", act_sum, 33'd0);
    chk("rst_mid_in_ready", {32'b0, act_in_ready}, 33'd1);
    seen = 0;
    repeat (4) begin
      step();
      @(negedge clk);
      if (act_out_valid) seen++;
    end
    chk("rst_mid_no_stale", 33'(seen), 33'd0);
    step();
    lat_chk = 1'b1;
    send_expect("post_rst", 32'h12345, 32'h0ABCD, 1'b1, 1'b0, 33'h01CF13);
    lat_chk = 1'b0;
  endtask

  initial begin
    fork
      monitor();
    join_none

    step();
    step();
    @(negedge clk);
    chk("rst_valid", {30'b0, ov0, ov1, ov2}, 33'd0);
    chk("rst_ready", {30'b0, ir0, ir1, ir2}, 33'd7);
    chk("rst_sum0", {12'd0, s0}, 33'd0);
    chk("rst_sum1", s1, 33'd0);
    chk("rst_sum2", {12'd0, s2}, 33'd0);
    step();
    rst = 1'b0;
    step();

    cfg = 0;
    lat_chk = 1'b1;
    send_expect("d0_carry_ripple", 32'hFFFFF, 32'h00001, 1'b0, 1'b0, 33'h100000);
    send_expect("d0_cin_only",     32'h00000, 32'h00000, 1'b1, 1'b0, 33'h000001);
    send_expect("d0_sub_borrow",   32'h00005, 32'h00007, 1'b0, 1'b1, 33'h0FFFFE);
    send_expect("d0_sub_noborrow", 32'h00007, 32'h00005, 1'b0, 1'b1, 33'h100002);
    send_expect("d0_sub_cin_ign",  32'h00007, 32'h00005, 1'b1, 1'b1, 33'h100002);
    stream(100, 100, 1'b0);
    lat_chk = 1'b0;
    stream(60, 70, 1'b1);
    backpressure();
    reset_mid();

    cfg = 1;
    lat_chk = 1'b1;
    send_expect("d1_carry_ripple", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 33'h100000000);
    send_expect("d1_sub_zero",     32'h0, 32'h0, 1'b0, 1'b1, 33'h100000000);
    stream(100, 100, 1'b0);
    lat_chk = 1'b0;
    stream(60, 70, 1'b1);

    cfg = 2;
    lat_chk = 1'b1;
    send_expect("d2_carry_ripple", 32'hFFFFF, 32'h00001, 1'b0, 1'b0, 33'h100000);
    send_expect("d2_sub_borrow",   32'h00005, 32'h00007, 1'b0, 1'b1, 33'h0FFFFE);
    stream(100, 100, 1'b0);
    lat_chk = 1'b0;
    stream(60, 70, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
